// File: rtl/fm_afc_if.sv
// fm_afc_if: system/demodulator-facing signal group of the AFC sequencer.
// master = system side (control and demod stream), slave = fm_afc_ctrl.
interface fm_afc_if #(
    parameter int DW = 16,
    parameter int PW = 32
);
    logic                 enable;
    logic [PW-1:0]        phi_init;
    logic signed [DW-1:0] demod_in;
    logic                 demod_valid;
    logic [PW-1:0]        phi_inc;
    logic                 locked;
    logic signed [DW-1:0] err_out;
    logic                 update_pulse;
    logic [2:0]           state_out;

    modport master (
        output enable, phi_init, demod_in, demod_valid,
        input  phi_inc, locked, err_out, update_pulse, state_out
    );

    modport slave (
        input  enable, phi_init, demod_in, demod_valid,
        output phi_inc, locked, err_out, update_pulse, state_out
    );
endinterface

// File: rtl/fm_afc_ctrl.sv
// fm_afc_ctrl: automatic frequency control sequencer for the FM demod NCO.
// Averages demod_in over 2^WIN_LOG2 valid samples, treats the floored mean
// as carrier error and steps phi_inc by err <<< KSHIFT; declares lock after
// LOCK_CNT consecutive small-error windows.
// Optional macro AFC_CLAMP_EN: keeps phi_inc within +/-PHI_RANGE of the
// phi_init captured on IDLE exit (saturating, no wrap) and masks locked while
// phi_inc sits on a clamp limit. Without it phi_inc wraps modulo 2^PW.
module fm_afc_ctrl #(
    parameter int DW         = 16,
    parameter int PW         = 32,
    parameter int WIN_LOG2   = 10,
    parameter int SETTLE_CYC = 256,
    parameter int KSHIFT     = 4,
    parameter int LOCK_THR   = 64,
    parameter int LOCK_CNT   = 4,
    parameter int PHI_RANGE  = 4294967
) (
    input logic     clk,
    input logic     rst_n,
    fm_afc_if.slave bus
);

    localparam int AW = DW + WIN_LOG2;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_ACCUM  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_CNT);
    localparam logic [DW-1:0] THR         = DW'(LOCK_THR);
    localparam logic [DW-1:0] THR2        = DW'(2 * LOCK_THR);
    localparam logic [DW-1:0] ERR_MIN     = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] ERR_MAX     = {1'b0, {(DW-1){1'b1}}};

    logic [2:0]           state;
    logic [PW-1:0]        phi_inc_q;
    logic                 locked_q;
    logic signed [DW-1:0] err_q;
    logic                 pulse_q;
    logic signed [AW-1:0] acc;
    logic [WIN_LOG2-1:0]  sample_cnt;
    logic [SW-1:0]        settle_cnt;
    logic [GW-1:0]        good_cnt;

    logic signed [DW-1:0] err;
    logic [DW-1:0]        abs_err;
    logic [PW-1:0]        step_ext;
    logic [PW-1:0]        step;
    logic [PW-1:0]        phi_next;
    logic [GW-1:0]        good_next;
    logic                 at_limit;

`ifdef AFC_CLAMP_EN
    localparam logic signed [PW:0] RANGE_P = (PW+1)'(PHI_RANGE);
    localparam logic signed [PW:0] RANGE_N = -RANGE_P;
    localparam logic [PW-1:0]      LIM_P   = PW'(PHI_RANGE);
    localparam logic [PW-1:0]      LIM_N   = -LIM_P;

    logic [PW-1:0]        phi_base;
    logic [PW-1:0]        offset;
    logic signed [PW:0]   new_off;
`endif

    // Window mean (floor via the top DW bits of acc), magnitude, loop step and next phi_inc.
    always_comb begin
        err      = acc[AW-1:WIN_LOG2];
        if (err == ERR_MIN)
            abs_err = ERR_MAX;
        else if (err[DW-1])
            abs_err = -err;
        else
            abs_err = err;
        step_ext  = {{(PW-DW){err[DW-1]}}, err};
        step      = step_ext << KSHIFT;
        good_next = (abs_err <= THR) ? good_cnt + GW'(1) : '0;
`ifdef AFC_CLAMP_EN
        offset  = phi_inc_q - phi_base;
        new_off = $signed({offset[PW-1], offset}) + $signed({step[PW-1], step});
        if (new_off > RANGE_P)
            new_off = RANGE_P;
        else if (new_off < RANGE_N)
            new_off = RANGE_N;
        phi_next = phi_base + new_off[PW-1:0];
        at_limit = (offset == LIM_P) || (offset == LIM_N);
`else
        phi_next = phi_inc_q + step;
        at_limit = 1'b0;
`endif
    end

    // Sequencer: settle, accumulate a window, apply the loop update, track lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phi_inc_q  <= '0;
            locked_q   <= 1'b0;
            err_q      <= '0;
            pulse_q    <= 1'b0;
            acc        <= '0;
            sample_cnt <= '0;
            settle_cnt <= '0;
            good_cnt   <= '0;
`ifdef AFC_CLAMP_EN
            phi_base   <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        phi_inc_q  <= bus.phi_init;
`ifdef AFC_CLAMP_EN
                        phi_base   <= bus.phi_init;
`endif
                        good_cnt   <= '0;
                        settle_cnt <= '0;
                        acc        <= '0;
                        sample_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    acc        <= '0;
                    sample_cnt <= '0;
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= S_ACCUM;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                S_ACCUM, S_LOCKED: begin
                    if (bus.demod_valid) begin
                        acc        <= acc + {{WIN_LOG2{bus.demod_in[DW-1]}}, bus.demod_in};
                        sample_cnt <= sample_cnt + WIN_LOG2'(1);
                        if (sample_cnt == '1)
                            state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    err_q      <= err;
                    phi_inc_q  <= phi_next;
                    pulse_q    <= 1'b1;
                    settle_cnt <= '0;
                    if (!locked_q) begin
                        good_cnt <= good_next;
                        if (good_next == GOOD_TARGET) begin
                            locked_q <= 1'b1;
                            acc      <= '0;
                            state    <= S_LOCKED;
                        end else begin
                            state <= S_SETTLE;
                        end
                    end else if (abs_err > THR2) begin
                        locked_q <= 1'b0;
                        good_cnt <= '0;
                        state    <= S_SETTLE;
                    end else begin
                        acc   <= '0;
                        state <= S_LOCKED;
                    end
                end
                default: state <= S_IDLE;
            endcase
            if (!bus.enable) begin
                state      <= S_IDLE;
                locked_q   <= 1'b0;
                acc        <= '0;
                sample_cnt <= '0;
                settle_cnt <= '0;
                good_cnt   <= '0;
            end
        end
    end

    assign bus.phi_inc      = phi_inc_q;
    assign bus.locked       = locked_q & ~at_limit;
    assign bus.err_out      = err_q;
    assign bus.update_pulse = pulse_q;
    assign bus.state_out    = state;

endmodule

// File: tb/tb_fm_afc_ctrl.sv
// tb_fm_afc_ctrl: table-driven bench for fm_afc_ctrl (default build, no clamp).
// Each table row runs one averaging window and checks the post-UPDATE outputs.
module tb_fm_afc_ctrl;
    localparam int DW = 16;
    localparam int PW = 32;
    localparam int WIN = 1024;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_ACCUM  = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;
    localparam logic signed [DW-1:0] JUNK = 16'sh7FFF;

    typedef struct {
        bit                   new_run;
        logic [PW-1:0]        phi_init;
        logic signed [DW-1:0] main_val;
        logic signed [DW-1:0] last_val;
        logic signed [DW-1:0] exp_err;
        logic [PW-1:0]        exp_phi;
        bit                   exp_locked;
        logic [2:0]           exp_state;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total_checks = 0;
    int   passed_checks = 0;
    vec_t vecs[16];

    fm_afc_if #(.DW(DW), .PW(PW)) afc_bus();

    fm_afc_ctrl #(.DW(DW), .PW(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (afc_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_checks++;
        if (actual === expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got 0x%h, want 0x%h", name, actual, expected);
    endtask

    // Disable, load phi_init, enable; check reload and the settle length.
    task automatic start_run(input logic [PW-1:0] init);
        int cnt;
        @(negedge clk);
        afc_bus.enable      = 1'b0;
        afc_bus.demod_valid = 1'b0;
        @(negedge clk);
        afc_bus.phi_init = init;
        afc_bus.enable   = 1'b1;
        @(negedge clk);
        afc_bus.demod_valid = 1'b1;
        afc_bus.demod_in    = JUNK;
        check_output("settle_entry_state", 32'(afc_bus.state_out), 32'(ST_SETTLE));
        check_output("phi_reload", afc_bus.phi_inc, init);
        cnt = 0;
        while (afc_bus.state_out != ST_ACCUM && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        afc_bus.demod_valid = 1'b0;
        check_output("settle_len", 32'(cnt), 32'd256);
    endtask

    task automatic wait_state(input logic [2:0] target, input string name);
        int cnt;
        cnt = 0;
        while (afc_bus.state_out != target && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 2000) begin
            total_checks++;
            $display("[TB] FAIL %s: state wait timed out, got %0d want %0d", name, afc_bus.state_out, target);
        end
    endtask

    // Feed one window (valid 3 of 4 cycles, junk on idle/settle cycles), then
    // a junk valid in the UPDATE cycle; returns at the cycle after UPDATE.
    task automatic apply_stimulus(input logic signed [DW-1:0] main_val,
                                  input logic signed [DW-1:0] last_val,
                                  input bit drop_enable);
        int accepted;
        int cyc;
        accepted = 0;
        cyc = 0;
        while (accepted < WIN && cyc < 20000) begin
            @(negedge clk);
            if (afc_bus.state_out == ST_ACCUM || afc_bus.state_out == ST_LOCKED) begin
                if (cyc % 4 != 3) begin
                    afc_bus.demod_valid = 1'b1;
                    afc_bus.demod_in    = (accepted == WIN - 1) ? last_val : main_val;
                    accepted++;
                end else begin
                    afc_bus.demod_valid = 1'b0;
                    afc_bus.demod_in    = JUNK;
                end
            end else begin
                afc_bus.demod_valid = 1'b1;
                afc_bus.demod_in    = JUNK;
            end
            cyc++;
        end
        if (accepted < WIN) begin
            total_checks++;
            $display("[TB] FAIL window_feed: accepted %0d of %0d samples", accepted, WIN);
        end
        @(negedge clk);
        check_output("update_state", 32'(afc_bus.state_out), 32'(ST_UPDATE));
        afc_bus.demod_valid = 1'b1;
        afc_bus.demod_in    = JUNK;
        if (drop_enable)
            afc_bus.enable = 1'b0;
        @(negedge clk);
        afc_bus.demod_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'd42949673, 16'sd0,     16'sd0,     16'sd0,     32'd42949673, 1'b0, ST_SETTLE};
        vecs[1]  = '{1'b0, 32'd0,        16'sd0,     16'sd0,     16'sd0,     32'd42949673, 1'b0, ST_SETTLE};
        vecs[2]  = '{1'b0, 32'd0,        16'sd0,     16'sd0,     16'sd0,     32'd42949673, 1'b0, ST_SETTLE};
        vecs[3]  = '{1'b0, 32'd0,        16'sd0,     16'sd0,     16'sd0,     32'd42949673, 1'b1, ST_LOCKED};
        vecs[4]  = '{1'b0, 32'd0,        16'sd200,   16'sd200,   16'sd200,   32'd42952873, 1'b0, ST_SETTLE};
        vecs[5]  = '{1'b1, 32'd42949673, 16'sd1000,  16'sd1000,  16'sd1000,  32'd42965673, 1'b0, ST_SETTLE};
        vecs[6]  = '{1'b1, 32'd42949673, 16'sh8000,  16'sh8000,  16'sh8000,  32'd42425385, 1'b0, ST_SETTLE};
        vecs[7]  = '{1'b0, 32'd0,        16'sh8000,  16'sh8000,  16'sh8000,  32'd41901097, 1'b0, ST_SETTLE};
        vecs[8]  = '{1'b1, 32'hFFFFFFF0, 16'sd1,     16'sd1,     16'sd1,     32'h00000000, 1'b0, ST_SETTLE};
        vecs[9]  = '{1'b1, 32'd5000,     16'sd0,     -16'sd1,    -16'sd1,    32'd4984,     1'b0, ST_SETTLE};
        vecs[10] = '{1'b1, 32'd1000,     16'sd64,    16'sd64,    16'sd64,    32'd2024,     1'b0, ST_SETTLE};
        vecs[11] = '{1'b0, 32'd0,        16'sd64,    16'sd64,    16'sd64,    32'd3048,     1'b0, ST_SETTLE};
        vecs[12] = '{1'b0, 32'd0,        16'sd64,    16'sd64,    16'sd64,    32'd4072,     1'b0, ST_SETTLE};
        vecs[13] = '{1'b0, 32'd0,        16'sd64,    16'sd64,    16'sd64,    32'd5096,     1'b1, ST_LOCKED};
        vecs[14] = '{1'b0, 32'd0,        16'sd128,   16'sd128,   16'sd128,   32'd7144,     1'b1, ST_LOCKED};
        vecs[15] = '{1'b0, 32'd0,        -16'sd129,  -16'sd129,  -16'sd129,  32'd5080,     1'b0, ST_SETTLE};

        // Power-on reset values.
        rst_n               = 1'b0;
        afc_bus.enable      = 1'b0;
        afc_bus.phi_init    = '0;
        afc_bus.demod_in    = '0;
        afc_bus.demod_valid = 1'b0;
        #12;
        check_output("rst_phi", afc_bus.phi_inc, 32'd0);
        check_output("rst_state", 32'(afc_bus.state_out), 32'(ST_IDLE));
        check_output("rst_locked", 32'(afc_bus.locked), 32'd0);
        check_output("rst_err", 32'(afc_bus.err_out), 32'd0);
        check_output("rst_pulse", 32'(afc_bus.update_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of an ACCUM window.
        start_run(32'd42949673);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            afc_bus.demod_valid = 1'b1;
            afc_bus.demod_in    = 16'sd1000;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_phi", afc_bus.phi_inc, 32'd0);
        check_output("midrst_state", 32'(afc_bus.state_out), 32'(ST_IDLE));
        check_output("midrst_locked", 32'(afc_bus.locked), 32'd0);
        check_output("midrst_err", 32'(afc_bus.err_out), 32'd0);
        check_output("midrst_pulse", 32'(afc_bus.update_pulse), 32'd0);
        @(negedge clk);
        rst_n               = 1'b1;
        afc_bus.demod_valid = 1'b0;

        // Table of windows.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].new_run)
                start_run(vecs[i].phi_init);
            apply_stimulus(vecs[i].main_val, vecs[i].last_val, 1'b0);
            check_output($sformatf("v%0d_pulse", i), 32'(afc_bus.update_pulse), 32'd1);
            check_output($sformatf("v%0d_err", i), 32'(afc_bus.err_out), 32'(vecs[i].exp_err));
            check_output($sformatf("v%0d_phi", i), afc_bus.phi_inc, vecs[i].exp_phi);
            check_output($sformatf("v%0d_locked", i), 32'(afc_bus.locked), 32'(vecs[i].exp_locked));
            check_output($sformatf("v%0d_state", i), 32'(afc_bus.state_out), 32'(vecs[i].exp_state));
            @(negedge clk);
            check_output($sformatf("v%0d_pulse_end", i), 32'(afc_bus.update_pulse), 32'd0);
        end

        // enable falls during the UPDATE cycle: update applies, then IDLE.
        start_run(32'd1000);
        apply_stimulus(16'sd2, 16'sd2, 1'b1);
        check_output("updrop_state", 32'(afc_bus.state_out), 32'(ST_IDLE));
        check_output("updrop_phi", afc_bus.phi_inc, 32'd1032);
        check_output("updrop_err", 32'(afc_bus.err_out), 32'd2);
        check_output("updrop_pulse", 32'(afc_bus.update_pulse), 32'd1);
        check_output("updrop_locked", 32'(afc_bus.locked), 32'd0);

        // Disable mid-ACCUM holds phi_inc; re-enable reloads phi_init.
        start_run(32'd777);
        apply_stimulus(16'sd3, 16'sd3, 1'b0);
        check_output("dis_phi_upd", afc_bus.phi_inc, 32'd825);
        wait_state(ST_ACCUM, "dis_wait_accum");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            afc_bus.demod_valid = 1'b1;
            afc_bus.demod_in    = 16'sd3;
        end
        afc_bus.enable = 1'b0;
        @(negedge clk);
        afc_bus.demod_valid = 1'b0;
        check_output("dis_state", 32'(afc_bus.state_out), 32'(ST_IDLE));
        check_output("dis_phi_hold", afc_bus.phi_inc, 32'd825);
        check_output("dis_err_hold", 32'(afc_bus.err_out), 32'd3);
        repeat (3) @(negedge clk);
        check_output("dis_state_stay", 32'(afc_bus.state_out), 32'(ST_IDLE));
        start_run(32'd888);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
